// File: rtl/pong_if.sv
// Pong engine bus: control inputs, paddle positions, ball state and events.
// master drives controls and paddles; slave is the engine.
interface pong_if #(
    parameter int COORD_W = 11
);
    logic               frame_tick;
    logic               serve;
    logic               serve_dir_x;
    logic [COORD_W-1:0] pad_l_x;
    logic [COORD_W-1:0] pad_l_y;
    logic [COORD_W-1:0] pad_r_x;
    logic [COORD_W-1:0] pad_r_y;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic               dir_x;
    logic               dir_y;
    logic               hit_l;
    logic               hit_r;
    logic               wall_top;
    logic               wall_bot;
    logic               goal_l;
    logic               goal_r;
    logic [3:0]         score_l;
    logic [3:0]         score_r;
    logic               game_over;
    logic               busy;

    modport master (
        output frame_tick, serve, serve_dir_x,
        output pad_l_x, pad_l_y, pad_r_x, pad_r_y,
        input  ball_x, ball_y, dir_x, dir_y,
        input  hit_l, hit_r, wall_top, wall_bot,
        input  goal_l, goal_r, score_l, score_r,
        input  game_over, busy
    );

    modport slave (
        input  frame_tick, serve, serve_dir_x,
        input  pad_l_x, pad_l_y, pad_r_x, pad_r_y,
        output ball_x, ball_y, dir_x, dir_y,
        output hit_l, hit_r, wall_top, wall_bot,
        output goal_l, goal_r, score_l, score_r,
        output game_over, busy
    );
endinterface

// File: rtl/pong_collision_engine.sv
// Ball/paddle/wall engine: one frame per accepted frame_tick,
// latched in CALC, resolved and committed on the CALC->COMMIT edge.
module pong_collision_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int WALL_MARGIN = 10,
    parameter int COORD_W     = 11,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 64,
    parameter int SPEED       = 2,
    parameter int LOCKOUT     = 4,
    parameter int SERVE_DELAY = 30,
    parameter int MAX_SCORE   = 9
) (
    input logic   clk,
    input logic   reset,
    pong_if.slave bus
);
    localparam int SW = COORD_W + 2;
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam int CW = $clog2(SERVE_DELAY + 1);

    localparam logic [COORD_W-1:0] CX = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] CY = COORD_W'((SCREEN_H - BALL_SIZE) / 2);

    localparam logic signed [SW-1:0] K_MARGIN = SW'(WALL_MARGIN);
    localparam logic signed [SW-1:0] K_BALL   = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] K_PW     = SW'(PADDLE_W);
    localparam logic signed [SW-1:0] K_PH     = SW'(PADDLE_H);
    localparam logic signed [SW-1:0] K_SW     = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] K_SH     = SW'(SCREEN_H);
    localparam logic signed [SW-1:0] K_SPEED  = SW'(SPEED);
    localparam logic [3:0]           K_MAX    = 4'(MAX_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CALC,
        S_COMMIT,
        S_SCORED,
        S_OVER
    } state_t;

    state_t state, state_nx;

    logic [COORD_W-1:0]     ball_x, ball_y;
    logic                   dir_x, dir_y;
    logic                   hit_l_q, hit_r_q, top_q, bot_q, goal_l_q, goal_r_q;
    logic [3:0]             score_l, score_r;
    logic [LW-1:0]          lock;
    logic [CW-1:0]          cnt;
    logic signed [SW-1:0]   nx_q, ny_q;
    logic signed [SW-1:0]   plx, ply, prx, pry;

    logic                   c_top, c_bot, c_hl, c_hr, c_gl, c_gr, c_goal;
    logic [COORD_W-1:0]     x_new, y_new;
    logic                   dx_new, dy_new;

    assign plx = $signed({2'b00, bus.pad_l_x});
    assign ply = $signed({2'b00, bus.pad_l_y});
    assign prx = $signed({2'b00, bus.pad_r_x});
    assign pry = $signed({2'b00, bus.pad_r_y});

    // Resolve walls, paddles and goals for the latched next position.
    always_comb begin
        c_top  = (ny_q <= K_MARGIN);
        c_bot  = !c_top && (ny_q + K_BALL >= K_SH);
        c_hr   = dir_x && (lock == '0)
               && (nx_q + K_BALL >= prx) && (nx_q <= prx + K_PW)
               && (ny_q + K_BALL >= pry) && (ny_q <= pry + K_PH);
        c_hl   = !dir_x && (lock == '0)
               && (nx_q <= plx + K_PW) && (nx_q + K_BALL >= plx)
               && (ny_q + K_BALL >= ply) && (ny_q <= ply + K_PH);
        c_gr   = (nx_q <= K_MARGIN) && !c_hl;
        c_gl   = (nx_q + K_BALL >= K_SW) && !c_hr;
        c_goal = c_gl || c_gr;
        y_new  = COORD_W'(ny_q);
        dy_new = dir_y;
        if (c_top) begin
            y_new  = COORD_W'(K_MARGIN);
            dy_new = 1'b1;
        end else if (c_bot) begin
            y_new  = COORD_W'(K_SH - K_BALL);
            dy_new = 1'b0;
        end
        x_new  = COORD_W'(nx_q);
        dx_new = dir_x;
        if (c_hr) begin
            x_new  = COORD_W'(prx - K_BALL);
            dx_new = 1'b0;
        end else if (c_hl) begin
            x_new  = COORD_W'(plx + K_PW);
            dx_new = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state: serve, frame pipeline, serve delay and game end.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (bus.serve) state_nx = S_RUN;
            S_RUN:    if (bus.frame_tick) state_nx = S_CALC;
            S_CALC:   state_nx = S_COMMIT;
            S_COMMIT: state_nx = (goal_l_q || goal_r_q) ? S_SCORED : S_RUN;
            S_SCORED: begin
                if (bus.frame_tick && cnt == CW'(SERVE_DELAY - 1)) begin
                    if (score_l == K_MAX || score_r == K_MAX) state_nx = S_OVER;
                    else                                      state_nx = S_IDLE;
                end
            end
            S_OVER:   if (bus.serve) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Ball, direction, pulses, scores, lockout and serve-delay counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x   <= CX;
            ball_y   <= CY;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            hit_l_q  <= 1'b0;
            hit_r_q  <= 1'b0;
            top_q    <= 1'b0;
            bot_q    <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
            score_l  <= '0;
            score_r  <= '0;
            lock     <= '0;
            cnt      <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
        end else begin
            hit_l_q  <= 1'b0;
            hit_r_q  <= 1'b0;
            top_q    <= 1'b0;
            bot_q    <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.serve) begin
                        dir_x <= bus.serve_dir_x;
                        dir_y <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.frame_tick) begin
                        nx_q <= $signed({2'b00, ball_x}) + (dir_x ? K_SPEED : -K_SPEED);
                        ny_q <= $signed({2'b00, ball_y}) + (dir_y ? K_SPEED : -K_SPEED);
                    end
                end
                S_CALC: begin
                    ball_x   <= c_goal ? CX : x_new;
                    ball_y   <= c_goal ? CY : y_new;
                    dir_x    <= dx_new;
                    dir_y    <= dy_new;
                    hit_l_q  <= c_hl;
                    hit_r_q  <= c_hr;
                    top_q    <= c_top;
                    bot_q    <= c_bot;
                    goal_l_q <= c_gl;
                    goal_r_q <= c_gr;
                    if (c_gl && score_l != K_MAX) score_l <= score_l + 4'd1;
                    if (c_gr && score_r != K_MAX) score_r <= score_r + 4'd1;
                    if (c_hl || c_hr)    lock <= LW'(LOCKOUT);
                    else if (lock != '0) lock <= lock - LW'(1);
                    cnt <= '0;
                end
                S_SCORED: begin
                    if (bus.frame_tick) cnt <= cnt + CW'(1);
                end
                S_OVER: begin
                    if (bus.serve) begin
                        score_l <= '0;
                        score_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ball_x    = ball_x;
    assign bus.ball_y    = ball_y;
    assign bus.dir_x     = dir_x;
    assign bus.dir_y     = dir_y;
    assign bus.hit_l     = hit_l_q;
    assign bus.hit_r     = hit_r_q;
    assign bus.wall_top  = top_q;
    assign bus.wall_bot  = bot_q;
    assign bus.goal_l    = goal_l_q;
    assign bus.goal_r    = goal_r_q;
    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.game_over = (state == S_OVER);
    assign bus.busy      = (state == S_CALC) || (state == S_COMMIT);
endmodule
